// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control unit for a small 8-bit core.
//
// Fetches instruction bytes from instruction memory at pc, decodes them and
// drives register file / ALU control. Two-byte instructions (LDI, JZ) fetch
// their second byte into imm.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   instr          byte from instruction memory at address pc
//   instr_valid    instr is valid this cycle
//   alu_zero       ALU result-is-zero flag
//   pc             program counter / instruction memory address
//   instr_req      fetch request (FETCH and FETCH_IMM)
//   sr1, sr2, dr   register file addresses, decoded from IR
//   write          register file write strobe (one cycle, in EXEC)
//   alu_op         ALU operation select
//   wb_sel         write data select: 0 = ALU result, 1 = imm
//   imm            immediate byte
//   halted         core stopped
//   illegal        illegal opcode trapped
//
// Configuration macro: ILLEGAL_TRAP_EN
//   defined   - illegal opcode halts the core and sets illegal until reset
//   undefined - illegal opcode executes as NOP, illegal tied to 0

module unidade_controle (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    input  logic       alu_zero,
    output logic [7:0] pc,
    output logic       instr_req,
    output logic [1:0] sr1,
    output logic [1:0] sr2,
    output logic [1:0] dr,
    output logic       write,
    output logic [2:0] alu_op,
    output logic       wb_sel,
    output logic [7:0] imm,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StFetchImm,
        StExec,
        StHalt
    } state_e;

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpAdd = 4'h1;
    localparam logic [3:0] OpSub = 4'h2;
    localparam logic [3:0] OpAnd = 4'h3;
    localparam logic [3:0] OpOr  = 4'h4;
    localparam logic [3:0] OpMov = 4'h5;
    localparam logic [3:0] OpLdi = 4'h6;
    localparam logic [3:0] OpJz  = 4'h7;
    localparam logic [3:0] OpHlt = 4'hF;

    state_e     state_q, state_d;
    logic [7:0] pc_q;
    logic [7:0] ir_q;
    logic [7:0] imm_q;
    logic       z_q;
    logic [3:0] opcode;
    logic       op_two_byte;
    logic       op_writes;
    logic       op_sets_z;
    logic       op_illegal;

    assign opcode      = ir_q[7:4];
    assign op_two_byte = (opcode == OpLdi) || (opcode == OpJz);
    assign op_writes   = (opcode >= OpAdd) && (opcode <= OpLdi);
    assign op_sets_z   = (opcode >= OpAdd) && (opcode <= OpOr);
    // Opcodes 0x8..0xE are unassigned.
    assign op_illegal  = opcode[3] && (opcode != OpHlt);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (instr_valid) state_d = StDecode;
            end
            StDecode: begin
                if (op_two_byte) begin
                    state_d = StFetchImm;
                end else if (opcode == OpHlt) begin
                    state_d = StHalt;
`ifdef ILLEGAL_TRAP_EN
                end else if (op_illegal) begin
                    state_d = StHalt;
`endif
                end else begin
                    state_d = StExec;
                end
            end
            StFetchImm: begin
                if (instr_valid) state_d = StExec;
            end
            StExec:  state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Datapath registers: pc, IR, imm, zero flag
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= 8'h00;
            ir_q  <= 8'h00;
            imm_q <= 8'h00;
            z_q   <= 1'b0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (instr_valid) begin
                        ir_q <= instr;
                        pc_q <= pc_q + 8'd1;
                    end
                end
                StFetchImm: begin
                    if (instr_valid) begin
                        imm_q <= instr;
                        pc_q  <= pc_q + 8'd1;
                    end
                end
                StExec: begin
                    if (op_sets_z) z_q <= alu_zero;
                    if ((opcode == OpJz) && z_q) pc_q <= imm_q;
                end
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if ((state_q == StDecode) && op_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Output logic
    always_comb begin
        instr_req = (state_q == StFetch) || (state_q == StFetchImm);
        halted    = (state_q == StHalt);
        // Gated by reset so a reset landing on EXEC suppresses the write.
        write     = (state_q == StExec) && op_writes && !reset;
        wb_sel    = (state_q == StExec) && (opcode == OpLdi);
        alu_op    = 3'd0;
        case (opcode)
            OpAdd:   alu_op = 3'd0;
            OpSub:   alu_op = 3'd1;
            OpAnd:   alu_op = 3'd2;
            OpOr:    alu_op = 3'd3;
            OpMov:   alu_op = 3'd4;
            OpNop:   alu_op = 3'd0;
            default: alu_op = 3'd0;
        endcase
    end

    assign pc  = pc_q;
    assign imm = imm_q;
    assign dr  = ir_q[3:2];
    assign sr1 = ir_q[3:2];
    assign sr2 = ir_q[1:0];

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

    logic       clk;
    logic       reset;
    logic [7:0] instr;
    logic       instr_valid;
    logic       alu_zero;
    logic [7:0] pc;
    logic       instr_req;
    logic [1:0] sr1, sr2, dr;
    logic       write;
    logic [2:0] alu_op;
    logic       wb_sel;
    logic [7:0] imm;
    logic       halted;
    logic       illegal;

    logic [7:0] mem [256];
    int total = 0;
    int bad   = 0;

    unidade_controle dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .alu_zero(alu_zero), .pc(pc), .instr_req(instr_req), .sr1(sr1), .sr2(sr2),
        .dr(dr), .write(write), .alu_op(alu_op), .wb_sel(wb_sel), .imm(imm),
        .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; memory presents the byte at the new pc.
    task automatic step();
        @(posedge clk);
        #1;
        instr = mem[pc];
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Leaves the bench in cycle 1 (first FETCH after reset release).
    task automatic do_reset();
        #1;
        reset = 1'b1;
        instr_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        instr = mem[pc];
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", pc); end
        total++; if (instr_req !== 1'b1) begin bad++; $display("FAIL reset_req got=%b exp=1", instr_req); end
        total++; if ({write, wb_sel, halted, illegal} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {write, wb_sel, halted, illegal}); end
        total++; if ({imm, dr, sr1, sr2, alu_op} !== 17'd0) begin
            bad++; $display("FAIL reset_regs got=%h exp=0", {imm, dr, sr1, sr2, alu_op}); end
    endtask

    task automatic test_add();
        clear_mem();
        mem[0] = 8'h16;
        alu_zero = 1'b0;
        do_reset();
        total++; if (write !== 1'b0) begin bad++; $display("FAIL add_c1_write got=%b exp=0", write); end
        step();
        total++; if (write !== 1'b0 || instr_req !== 1'b0) begin
            bad++; $display("FAIL add_c2 got=w%b r%b exp=w0 r0", write, instr_req); end
        step();
        total++; if ({write, dr, sr1, sr2, alu_op, pc} !== {1'b1, 2'd1, 2'd1, 2'd2, 3'd0, 8'h01}) begin
            bad++; $display("FAIL add_c3 got=w%b dr%0d s1%0d s2%0d op%0d pc%h exp=w1 dr1 s11 s22 op0 pc01",
                            write, dr, sr1, sr2, alu_op, pc); end
        step();
        total++; if (write !== 1'b0 || instr_req !== 1'b1) begin
            bad++; $display("FAIL add_c4 got=w%b r%b exp=w0 r1", write, instr_req); end
    endtask

    task automatic test_ldi();
        clear_mem();
        mem[0] = 8'h68; mem[1] = 8'h5A;
        do_reset();
        run(2);
        total++; if (instr_req !== 1'b1 || write !== 1'b0 || pc !== 8'h01) begin
            bad++; $display("FAIL ldi_c3 got=r%b w%b pc%h exp=r1 w0 pc01", instr_req, write, pc); end
        step();
        total++; if ({write, wb_sel, imm, dr, pc} !== {1'b1, 1'b1, 8'h5A, 2'd2, 8'h02}) begin
            bad++; $display("FAIL ldi_c4 got=w%b s%b imm%h dr%0d pc%h exp=w1 s1 imm5a dr2 pc02",
                            write, wb_sel, imm, dr, pc); end
        step();
        total++; if (write !== 1'b0 || wb_sel !== 1'b0) begin
            bad++; $display("FAIL ldi_c5 got=w%b s%b exp=w0 s0", write, wb_sel); end
    endtask

    task automatic test_jz(input logic zero, input logic [7:0] exp_pc);
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h70; mem[2] = 8'h40;
        alu_zero = zero;
        do_reset();
        step();
        total++; if (alu_op !== 3'd1) begin bad++; $display("FAIL sub_aluop got=%0d exp=1", alu_op); end
        run(5);
        total++; if (write !== 1'b0 || pc !== 8'h03) begin
            bad++; $display("FAIL jz_exec got=w%b pc%h exp=w0 pc03", write, pc); end
        step();
        total++; if (pc !== exp_pc) begin bad++; $display("FAIL jz_pc z=%b got=%h exp=%h", zero, pc, exp_pc); end
    endtask

    task automatic test_z_hold();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h51; mem[2] = 8'h70; mem[3] = 8'h40;
        alu_zero = 1'b1;
        do_reset();
        run(3);
        alu_zero = 1'b0;
        run(2);
        total++; if ({write, wb_sel, alu_op, sr2} !== {1'b1, 1'b0, 3'd4, 2'd1}) begin
            bad++; $display("FAIL mov_exec got=w%b s%b op%0d s2%0d exp=w1 s0 op4 s21",
                            write, wb_sel, alu_op, sr2); end
        run(5);
        total++; if (pc !== 8'h40) begin bad++; $display("FAIL zhold_pc got=%h exp=40", pc); end
    endtask

    task automatic test_stall();
        clear_mem();
        mem[0] = 8'h16;
        do_reset();
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (instr_req !== 1'b1 || pc !== 8'h00 || write !== 1'b0) begin
                bad++; $display("FAIL stall_%0d got=r%b pc%h w%b exp=r1 pc00 w0", i, instr_req, pc, write); end
        end
        instr_valid = 1'b1;
        step();
        total++; if (instr_req !== 1'b0 || pc !== 8'h01) begin
            bad++; $display("FAIL stall_resume got=r%b pc%h exp=r0 pc01", instr_req, pc); end
    endtask

    task automatic test_halt();
        clear_mem();
        mem[0] = 8'hF0; mem[1] = 8'h16;
        do_reset();
        run(2);
        total++; if ({halted, instr_req, write} !== 3'b100) begin
            bad++; $display("FAIL hlt got=%b exp=100", {halted, instr_req, write}); end
        run(3);
        total++; if (halted !== 1'b1 || pc !== 8'h01) begin
            bad++; $display("FAIL hlt_hold got=h%b pc%h exp=h1 pc01", halted, pc); end
    endtask

    task automatic test_illegal();
        clear_mem();
        mem[0] = 8'h90;
        do_reset();
        run(2);
`ifdef ILLEGAL_TRAP_EN
        total++; if ({halted, illegal, instr_req, write} !== 4'b1100) begin
            bad++; $display("FAIL ill_trap got=%b exp=1100", {halted, illegal, instr_req, write}); end
        run(3);
        total++; if ({halted, illegal, pc} !== {2'b11, 8'h01}) begin
            bad++; $display("FAIL ill_hold got=%b pc%h exp=11 pc01", {halted, illegal}, pc); end
`else
        total++; if ({halted, illegal, instr_req, write} !== 4'b0000) begin
            bad++; $display("FAIL ill_nop got=%b exp=0000", {halted, illegal, instr_req, write}); end
        step();
        total++; if (instr_req !== 1'b1 || pc !== 8'h01 || illegal !== 1'b0) begin
            bad++; $display("FAIL ill_next got=r%b pc%h i%b exp=r1 pc01 i0", instr_req, pc, illegal); end
`endif
    endtask

    task automatic test_reset_in_exec();
        clear_mem();
        mem[0] = 8'h16;
        do_reset();
        run(2);
        reset = 1'b1;
        #1;
        total++; if (write !== 1'b0) begin bad++; $display("FAIL rst_exec_write got=%b exp=0", write); end
        step();
        reset = 1'b0;
        total++; if (pc !== 8'h00 || instr_req !== 1'b1) begin
            bad++; $display("FAIL rst_exec_after got=pc%h r%b exp=pc00 r1", pc, instr_req); end
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h70; mem[2] = 8'hFF; mem[255] = 8'h00;
        alu_zero = 1'b1;
        do_reset();
        run(7);
        total++; if (pc !== 8'hFF || instr_req !== 1'b1) begin
            bad++; $display("FAIL wrap_pre got=pc%h r%b exp=pcff r1", pc, instr_req); end
        step();
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL wrap_pc got=%h exp=00", pc); end
    endtask

    initial begin
        reset = 1'b1;
        instr = 8'h00;
        instr_valid = 1'b0;
        alu_zero = 1'b0;
        test_reset();
        test_add();
        test_ldi();
        test_jz(1'b1, 8'h40);
        test_jz(1'b0, 8'h03);
        test_z_hold();
        test_stall();
        test_halt();
        test_illegal();
        test_reset_in_exec();
        test_pc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
